// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular FIFO between prefetch and decode with fetch-exception hold.
// Optional FETCH_BUF_BYPASS_EN forwards prefetch straight to decode when the buffer is empty.
module fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pf_valid_i,
    input  logic [31:0]              pf_instr_i,
    input  logic [31:0]              pf_pc_i,
    input  logic                     pf_exc_i,
    output logic                     pf_ready_o,
    output logic                     id_valid_o,
    output logic [31:0]              id_instr_o,
    output logic [31:0]              id_pc_o,
    output logic                     id_exc_o,
    input  logic                     id_ready_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]  wptr, rptr;
    logic         exc_hold;
    logic [31:0]  mem_instr [DEPTH];
    logic [31:0]  mem_pc    [DEPTH];
    logic         mem_exc   [DEPTH];

    logic         empty, full, push, pop, bypass;
    logic [31:0]  head_instr, head_pc;
    logic         head_exc;

    assign head_instr = mem_instr[rptr[AW-1:0]];
    assign head_pc    = mem_pc[rptr[AW-1:0]];
    assign head_exc   = mem_exc[rptr[AW-1:0]];

    always_comb begin
        empty      = (wptr == rptr);
        full       = (wptr == {~rptr[AW], rptr[AW-1:0]});
        pf_ready_o = !full && !exc_hold && !flush_i;
`ifdef FETCH_BUF_BYPASS_EN
        bypass     = empty && pf_valid_i && id_ready_i && !flush_i && !exc_hold;
`else
        bypass     = 1'b0;
`endif
        // A bypassed instruction is consumed directly and never occupies a slot.
        push       = pf_valid_i && pf_ready_o && !bypass;
        pop        = !empty && !flush_i && id_ready_i;
        id_valid_o = (!empty && !flush_i) || bypass;
        count_o    = wptr - rptr;
        id_instr_o = '0;
        id_pc_o    = '0;
        id_exc_o   = 1'b0;
        if (bypass) begin
            id_instr_o = pf_instr_i;
            id_pc_o    = pf_pc_i;
            id_exc_o   = pf_exc_i;
        end else if (!empty) begin
            id_instr_o = head_instr;
            id_pc_o    = head_pc;
            id_exc_o   = head_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wptr     <= '0;
            rptr     <= '0;
            exc_hold <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            // Only one faulting entry can be buffered, so popping any faulting head releases the hold.
            if (push && pf_exc_i)
                exc_hold <= 1'b1;
            else if (pop && head_exc)
                exc_hold <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_instr[wptr[AW-1:0]] <= pf_instr_i;
            mem_pc[wptr[AW-1:0]]    <= pf_pc_i;
            mem_exc[wptr[AW-1:0]]   <= pf_exc_i;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: scoreboard queue models storage; a negedge monitor compares outputs.
// Build with FETCH_BUF_BYPASS_EN defined to check the bypass variant.
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n, pf_valid_i, pf_exc_i, pf_ready_o;
    logic [31:0]   pf_instr_i, pf_pc_i;
    logic          id_valid_o, id_exc_o, id_ready_i, flush_i;
    logic [31:0]   id_instr_o, id_pc_o;
    logic [CW-1:0] count_o;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .pf_valid_i(pf_valid_i), .pf_instr_i(pf_instr_i), .pf_pc_i(pf_pc_i), .pf_exc_i(pf_exc_i),
        .pf_ready_o(pf_ready_o),
        .id_valid_o(id_valid_o), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_exc_o(id_exc_o),
        .id_ready_i(id_ready_i), .flush_i(flush_i), .count_o(count_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } ent_t;

    ent_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic hold_m = 1'b0;
    logic chk_en = 1'b0;
    logic cur_acc, cur_pop, cur_byp, exp_ready, exp_valid;
    ent_t exp_head;

    function automatic void predict();
        int mc;
        mc      = sb.size();
        cur_byp = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
        cur_byp = rst_n && (mc == 0) && pf_valid_i && id_ready_i && !flush_i && !hold_m;
`endif
        exp_ready = (mc < DEPTH) && !hold_m && !flush_i;
        cur_acc   = rst_n && pf_valid_i && exp_ready && !cur_byp;
        cur_pop   = rst_n && (mc > 0) && id_ready_i && !flush_i;
        exp_valid = ((mc > 0) && !flush_i) || cur_byp;
        if (cur_byp)
            exp_head = {pf_instr_i, pf_pc_i, pf_exc_i};
        else if (mc > 0)
            exp_head = sb[0];
        else
            exp_head = '0;
    endfunction

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic e, input logic rdy, input logic fl);
        pf_valid_i = v;
        pf_instr_i = instr;
        pf_pc_i    = pc;
        pf_exc_i   = e;
        id_ready_i = rdy;
        flush_i    = fl;
        predict();
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (!rst_n || flush_i) begin
            sb.delete();
            hold_m = 1'b0;
        end else begin
            if (cur_pop) begin
                e = sb.pop_front();
                if (e.exc) hold_m = 1'b0;
            end
            if (cur_acc) begin
                sb.push_back({pf_instr_i, pf_pc_i, pf_exc_i});
                if (pf_exc_i) hold_m = 1'b1;
            end
        end
        #1;
        predict();
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            checks++;
            if (pf_ready_o !== exp_ready) begin
                errors++;
                $display("FAIL mon_pf_ready t=%0t got %b want %b", $time, pf_ready_o, exp_ready);
            end
            checks++;
            if (id_valid_o !== exp_valid) begin
                errors++;
                $display("FAIL mon_id_valid t=%0t got %b want %b", $time, id_valid_o, exp_valid);
            end
            checks++;
            if (count_o !== CW'(sb.size())) begin
                errors++;
                $display("FAIL mon_count t=%0t got %0d want %0d", $time, count_o, sb.size());
            end
            checks++;
            if ({id_instr_o, id_pc_o, id_exc_o} !== exp_head) begin
                errors++;
                $display("FAIL mon_head t=%0t got %h/%h/%b want %h/%h/%b", $time,
                         id_instr_o, id_pc_o, id_exc_o, exp_head.instr, exp_head.pc, exp_head.exc);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, '0, '0, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        predict();
        checks++; if (pf_ready_o !== 1'b1) begin errors++; $display("FAIL reset_pf_ready got %b want 1", pf_ready_o); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b want 0", id_valid_o); end
        checks++; if (id_instr_o !== 32'h0) begin errors++; $display("FAIL reset_id_instr got %h want 0", id_instr_o); end
        checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h want 0", id_pc_o); end
        checks++; if (id_exc_o !== 1'b0) begin errors++; $display("FAIL reset_id_exc got %b want 0", id_exc_o); end
        checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
        chk_en = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1000 + 32'(i), 32'(i * 4), 0, 0, 0);
            tick();
        end
        drive(1, 32'h1010, 32'h10, 0, 0, 0);
        #1;
        checks++; if (count_o !== CW'(4)) begin errors++; $display("FAIL fill_count got %0d want 4", count_o); end
        checks++; if (pf_ready_o !== 1'b0) begin errors++; $display("FAIL fill_pf_ready got %b want 0", pf_ready_o); end
        tick();
        checks++; if (count_o !== CW'(4)) begin errors++; $display("FAIL fill_fifth_push got count %0d want 4", count_o); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, '0, 0, 1, 0);
            #1;
            checks++;
            if (id_valid_o !== 1'b1 || id_pc_o !== 32'(i * 4)) begin
                errors++;
                $display("FAIL drain_order got valid %b pc %h want valid 1 pc %h", id_valid_o, id_pc_o, 32'(i * 4));
            end
            tick();
        end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %b want 0", id_valid_o); end
        checks++; if (count_o !== '0) begin errors++; $display("FAIL drain_empty_count got %0d want 0", count_o); end
    endtask

    task automatic test_back_to_back();
        drive(1, 32'h2100, 32'h100, 0, 0, 0); tick();
        drive(1, 32'h2104, 32'h104, 0, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h2108 + 32'(4 * i), 32'h108 + 32'(4 * i), 0, 1, 0);
            #1;
            checks++;
            if (count_o !== CW'(2) || id_pc_o !== 32'h100 + 32'(4 * i)) begin
                errors++;
                $display("FAIL b2b_cycle%0d got count %0d pc %h want count 2 pc %h", i, count_o, id_pc_o, 32'h100 + 32'(4 * i));
            end
            tick();
        end
        checks++; if (count_o !== CW'(2)) begin errors++; $display("FAIL b2b_final_count got %0d want 2", count_o); end
        drive(0, '0, '0, 0, 1, 0);
        repeat (2) tick();
    endtask

    task automatic test_exc_hold();
        logic found;
        found = 1'b0;
        drive(1, 32'h3000, 32'h0, 0, 0, 0); tick();
        drive(1, 32'h3004, 32'h4, 0, 0, 0); tick();
        drive(1, 32'h3008, 32'h8, 1, 0, 0); tick();
        drive(1, 32'h300C, 32'hC, 0, 0, 0);
        #1;
        checks++; if (pf_ready_o !== 1'b0) begin errors++; $display("FAIL exc_hold_ready got %b want 0", pf_ready_o); end
        tick();
        checks++; if (count_o !== CW'(3)) begin errors++; $display("FAIL exc_hold_count got %0d want 3", count_o); end
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h300C, 32'hC, 0, 1, 0);
            #1;
            checks++;
            if (pf_ready_o !== 1'b0) begin errors++; $display("FAIL exc_hold_wait_ready got %b want 0", pf_ready_o); end
            if (id_valid_o === 1'b1 && id_pc_o === 32'h8) begin
                found = 1'b1;
                checks++;
                if (id_exc_o !== 1'b1) begin errors++; $display("FAIL exc_head_flag got %b want 1", id_exc_o); end
                tick();
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL exc_pop_timeout got no pc 8 want pc 8 within 8 cycles"); end
        checks++; if (pf_ready_o !== 1'b1) begin errors++; $display("FAIL exc_release_ready got %b want 1", pf_ready_o); end
        drive(0, '0, '0, 0, 1, 0);
        repeat (2) tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h4000 + 32'(i), 32'h200 + 32'(4 * i), 0, 0, 0);
            tick();
        end
        drive(1, 32'h4300, 32'h300, 0, 1, 1);
        #1;
        checks++; if (pf_ready_o !== 1'b0) begin errors++; $display("FAIL flush_cycle_ready got %b want 0", pf_ready_o); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid got %b want 0", id_valid_o); end
        tick();
        drive(0, '0, '0, 0, 0, 0);
        #1;
        checks++; if (count_o !== '0) begin errors++; $display("FAIL flush_count got %0d want 0", count_o); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", id_valid_o); end
        tick();
    endtask

    task automatic test_bypass();
        drive(1, 32'h00200093, 32'h4, 0, 1, 0);
        #1;
`ifdef FETCH_BUF_BYPASS_EN
        checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL byp_valid got %b want 1", id_valid_o); end
        checks++; if (id_instr_o !== 32'h00200093) begin errors++; $display("FAIL byp_instr got %h want 00200093", id_instr_o); end
        checks++; if (count_o !== '0) begin errors++; $display("FAIL byp_count got %0d want 0", count_o); end
        tick();
        drive(0, '0, '0, 0, 1, 0);
        #1;
        checks++; if (count_o !== '0) begin errors++; $display("FAIL byp_after_count got %0d want 0", count_o); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL byp_after_valid got %b want 0", id_valid_o); end
        tick();
`else
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL nobyp_same_cycle_valid got %b want 0", id_valid_o); end
        tick();
        drive(0, '0, '0, 0, 1, 0);
        #1;
        checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL nobyp_next_valid got %b want 1", id_valid_o); end
        checks++; if (id_instr_o !== 32'h00200093) begin errors++; $display("FAIL nobyp_instr got %h want 00200093", id_instr_o); end
        checks++; if (count_o !== CW'(1)) begin errors++; $display("FAIL nobyp_count got %0d want 1", count_o); end
        tick();
        checks++; if (count_o !== '0) begin errors++; $display("FAIL nobyp_drained got %0d want 0", count_o); end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h5000 + 32'(i), 32'h400 + 32'(4 * i), 0, 0, 0);
            tick();
        end
        rst_n = 1'b0;
        drive(1, 32'h5500, 32'h500, 0, 1, 0);
        tick();
        rst_n = 1'b1;
        drive(0, '0, '0, 0, 1, 0);
        #1;
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", id_valid_o); end
        checks++; if (count_o !== '0) begin errors++; $display("FAIL rstmid_count got %0d want 0", count_o); end
        checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL rstmid_pc got %h want 0", id_pc_o); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom(), 32'h8000 + 32'(4 * i),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0));
            tick();
        end
        drive(0, '0, '0, 0, 1, 0);
        repeat (DEPTH + 1) tick();
        checks++; if (count_o !== '0) begin errors++; $display("FAIL random_drain_count got %0d want 0", count_o); end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, '0, '0, 0, 0, 0);
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_exc_hold();
        test_flush();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
